fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameters (name, default, meaning): PC_W, 9, PC and instruction-address width; INS_W, 32, instruction width; RESET_PC, 0, first fetch address; NOP_INSTR, 32'h00000013, IF/ID instruction value when invalid.
REQ-002 Clock is clk; reset is reset, synchronous, active-high; the block has one clock.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 stall  input  1  hazard unit: hold IF/ID contents.
REQ-006 redirect_valid  input  1  branch/jal/jalr taken: flush and refetch.
REQ-007 redirect_pc  input  PC_W  redirect target.
REQ-008 imem_req  output  1  fetch request.
REQ-009 imem_addr  output  PC_W  fetch address.
REQ-010 imem_rdy  input  1  response valid, completes the outstanding request.
REQ-011 imem_rdata  input  INS_W  instruction, valid with imem_rdy.
REQ-012 if_id_valid  output  1  IF/ID holds a real instruction.
REQ-013 if_id_pc, if_id_pcplus4  output  PC_W each  PC of the held instruction and PC+4.
REQ-014 if_id_instr  output  INS_W  held instruction.
REQ-015 fetch_misalign  output  1  misaligned redirect flag (see Configuration).

Function
REQ-016 States: FETCH (imem_req=1, imem_addr=pc), DROP (imem_req=1, imem_addr=saved request address, response discarded), HOLD (imem_req=0, one-entry buffer full).
REQ-017 Request handshake: imem_addr is stable while imem_req=1 until the cycle imem_rdy=1; imem_rdy is ignored when imem_req=0.
REQ-018 FETCH, imem_rdy=1, stall=0, no redirect: IF/ID loads {1, pc, pc+4, imem_rdata} at the next edge; pc becomes pc+4; state stays FETCH.
REQ-019 Latency: imem_rdy in cycle N leads to the instruction on if_id_* in cycle N+1. With imem_rdy tied high, throughput is one instruction per cycle.
REQ-020 PC arithmetic: pc+4 is modulo 2^PC_W, so 9'h1FC+4 wraps to 9'h000; if_id_pcplus4 uses the same wrap.
REQ-021 FETCH, imem_rdy=1, stall=1: the response and its pc go to the buffer; pc advances by 4; next state is HOLD; IF/ID is unchanged.
REQ-022 HOLD, stall=0: the buffer moves into IF/ID; next state is FETCH. HOLD, stall=1: everything is held.
REQ-023 stall=1 without a response: IF/ID is held; FETCH continues waiting for imem_rdy.
REQ-024 redirect_valid=1 has priority over stall and imem_rdy in every state: if_id_valid becomes 0, if_id_instr becomes NOP_INSTR, the buffer is emptied, and pc becomes redirect_pc.
REQ-025 Redirect in FETCH with imem_rdy=0: the old address is saved and the next state is DROP. With imem_rdy=1, the response is discarded and the next state is FETCH at the new pc.
REQ-026 DROP: the response is discarded when imem_rdy=1, then the next state is FETCH. A second redirect while in DROP updates pc only.
REQ-027 Redirect in HOLD: the next state is FETCH, since no request is outstanding.
REQ-028 IF/ID fields other than valid and instr keep their stale values when flushed.

Reset
REQ-029 While reset=1 at an edge: state becomes FETCH, pc becomes RESET_PC, the buffer is emptied, if_id_valid=0, if_id_instr=NOP_INSTR, if_id_pc=0, if_id_pcplus4=0, and fetch_misalign=0.
REQ-030 imem_req is 0 during any cycle in which reset=1. In the first cycle after reset, imem_req=1 and imem_addr=RESET_PC.
REQ-031 Reset mid-transaction abandons the outstanding request; the memory model must tolerate a dropped request.

Configuration
REQ-032 Macro FETCH_MISALIGN_CHK_EN, when defined: a redirect with redirect_pc[1:0]!=0 loads pc with redirect_pc[1:0] forced to 00, and fetch_misalign=1 for the one cycle after the redirect edge.
REQ-033 When FETCH_MISALIGN_CHK_EN is undefined: redirect_pc is used unmodified and fetch_misalign is tied to 0.

Verification
REQ-034 Reset, then imem_rdy tied 1 with rdata=addr-tagged words: if_id_pc runs 0,4,8,... one per cycle, with if_id_valid=1 from cycle 2.
REQ-035 imem_rdy=1 in the same cycle as stall=1 with rdata=32'hDEADBEEF, stall held 3 cycles: IF/ID holds its old value; imem_req=0 during the stall; after release, if_id_instr=32'hDEADBEEF.
REQ-036 Request to 0x10 pending (rdy=0), redirect_pc=0x40: the response to 0x10 arrives 2 cycles later and is discarded; the next imem_addr is 0x40 and if_id_pc=0x40.
REQ-037 Redirect and stall asserted together with IF/ID valid: if_id_valid=0 and if_id_instr=32'h00000013 next cycle.
REQ-038 pc=0x1FC fetched: if_id_pcplus4=0x000 and the next imem_addr=0x000. With the macro defined, redirect_pc=0x42 gives imem_addr=0x40 and a 1-cycle fetch_misalign pulse.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: RISC-V instruction fetch with one-entry skid buffer.
// Optional FETCH_MISALIGN_CHK_EN: align redirect targets, flag misalign.
module fetch_stage #(
  parameter int unsigned           PC_W      = 9,
  parameter int unsigned           INS_W     = 32,
  parameter logic [PC_W-1:0]       RESET_PC  = '0,
  parameter logic [INS_W-1:0]      NOP_INSTR = 32'h00000013
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [PC_W-1:0]  redirect_pc,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic             imem_rdy,
  input  logic [INS_W-1:0] imem_rdata,
  output logic             if_id_valid,
  output logic [PC_W-1:0]  if_id_pc,
  output logic [PC_W-1:0]  if_id_pcplus4,
  output logic [INS_W-1:0] if_id_instr,
  output logic             fetch_misalign
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DROP  = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t            state;
  logic [PC_W-1:0]   pc;
  logic [PC_W-1:0]   save_addr;
  logic [PC_W-1:0]   buf_pc;
  logic [INS_W-1:0]  buf_instr;
  logic [PC_W-1:0]   pc_next4;
  logic [PC_W-1:0]   buf_next4;
  logic [PC_W-1:0]   target;
  logic              mis;

  assign pc_next4  = pc + PC_W'(4);
  assign buf_next4 = buf_pc + PC_W'(4);

`ifdef FETCH_MISALIGN_CHK_EN
  assign target = {redirect_pc[PC_W-1:2], 2'b00};
  assign mis    = |redirect_pc[1:0];
`else
  assign target = redirect_pc;
  assign mis    = 1'b0;
`endif

  // Request is suppressed in reset and while the buffer is full.
  assign imem_req  = !reset && (state != HOLD);
  assign imem_addr = (state == DROP) ? save_addr : pc;

  // Fetch FSM, PC, skid buffer and IF/ID register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= FETCH;
      pc             <= RESET_PC;
      save_addr      <= RESET_PC;
      buf_pc         <= '0;
      buf_instr      <= NOP_INSTR;
      if_id_valid    <= 1'b0;
      if_id_pc       <= '0;
      if_id_pcplus4  <= '0;
      if_id_instr    <= NOP_INSTR;
      fetch_misalign <= 1'b0;
    end else begin
      fetch_misalign <= 1'b0;
      if (redirect_valid) begin
        if_id_valid    <= 1'b0;
        if_id_instr    <= NOP_INSTR;
        pc             <= target;
        fetch_misalign <= mis;
        buf_instr      <= NOP_INSTR;
        unique case (state)
          FETCH: begin
            if (imem_rdy) begin
              state <= FETCH;
            end else begin
              state     <= DROP;
              save_addr <= pc;
            end
          end
          DROP: begin
            state <= imem_rdy ? FETCH : DROP;
          end
          default: begin
            state <= FETCH;
          end
        endcase
      end else begin
        unique case (state)
          FETCH: begin
            if (imem_rdy) begin
              pc <= pc_next4;
              if (stall) begin
                buf_pc    <= pc;
                buf_instr <= imem_rdata;
                state     <= HOLD;
              end else begin
                if_id_valid   <= 1'b1;
                if_id_pc      <= pc;
                if_id_pcplus4 <= pc_next4;
                if_id_instr   <= imem_rdata;
              end
            end else if (!stall) begin
              if_id_valid <= 1'b0;
              if_id_instr <= NOP_INSTR;
            end
          end
          DROP: begin
            if (imem_rdy) begin
              state <= FETCH;
            end
            if (!stall) begin
              if_id_valid <= 1'b0;
              if_id_instr <= NOP_INSTR;
            end
          end
          default: begin
            if (!stall) begin
              if_id_valid   <= 1'b1;
              if_id_pc      <= buf_pc;
              if_id_pcplus4 <= buf_next4;
              if_id_instr   <= buf_instr;
              state         <= FETCH;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vectors for fetch_stage.
// Define FETCH_MISALIGN_CHK_EN to check the aligned-redirect variant.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [8:0]  redirect_pc;
  logic        imem_req;
  logic [8:0]  imem_addr;
  logic        imem_rdy;
  logic [31:0] imem_rdata;
  logic        if_id_valid;
  logic [8:0]  if_id_pc;
  logic [8:0]  if_id_pcplus4;
  logic [31:0] if_id_instr;
  logic        fetch_misalign;

  logic        tag_mode;
  logic [31:0] rdata;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign imem_rdata = tag_mode ? (32'hA000_0000 | 32'(imem_addr)) : rdata;

  fetch_stage dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdy       (imem_rdy),
    .imem_rdata     (imem_rdata),
    .if_id_valid    (if_id_valid),
    .if_id_pc       (if_id_pc),
    .if_id_pcplus4  (if_id_pcplus4),
    .if_id_instr    (if_id_instr),
    .fetch_misalign (fetch_misalign)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    imem_rdy = 1'b0;
    tag_mode = 1'b0;
    rdata = '0;

    step();
    step();
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_valid", 32'(if_id_valid), 0);
    chk("rst_instr", if_id_instr, 32'h13);
    chk("rst_pc", 32'(if_id_pc), 0);
    chk("rst_pc4", 32'(if_id_pcplus4), 0);
    chk("rst_mis", 32'(fetch_misalign), 0);

    reset = 1'b0;
    tag_mode = 1'b1;
    imem_rdy = 1'b1;
    #1;
    chk("c1_req", 32'(imem_req), 1);
    chk("c1_addr", 32'(imem_addr), 0);
    chk("c1_valid", 32'(if_id_valid), 0);

    for (int i = 0; i < 3; i++) begin
      step();
      chk("str_valid", 32'(if_id_valid), 1);
      chk("str_pc", 32'(if_id_pc), 32'(i * 4));
      chk("str_pc4", 32'(if_id_pcplus4), 32'(i * 4 + 4));
      chk("str_instr", if_id_instr, 32'hA000_0000 | 32'(i * 4));
      chk("str_addr", 32'(imem_addr), 32'(i * 4 + 4));
    end

    tag_mode = 1'b0;
    rdata = 32'hDEAD_BEEF;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stl_req", 32'(imem_req), 0);
      chk("stl_pc", 32'(if_id_pc), 32'h8);
      chk("stl_instr", if_id_instr, 32'hA000_0008);
    end
    stall = 1'b0;
    imem_rdy = 1'b0;
    rdata = '0;
    step();
    chk("rel_instr", if_id_instr, 32'hDEAD_BEEF);
    chk("rel_pc", 32'(if_id_pc), 32'hC);
    chk("rel_pc4", 32'(if_id_pcplus4), 32'h10);
    chk("rel_req", 32'(imem_req), 1);
    chk("rel_addr", 32'(imem_addr), 32'h10);

    redirect_valid = 1'b1;
    redirect_pc = 9'h040;
    step();
    redirect_valid = 1'b0;
    chk("rd_valid", 32'(if_id_valid), 0);
    chk("rd_instr", if_id_instr, 32'h13);
    chk("rd_stale_pc", 32'(if_id_pc), 32'hC);
    chk("drop_addr0", 32'(imem_addr), 32'h10);
    step();
    chk("drop_addr1", 32'(imem_addr), 32'h10);
    imem_rdy = 1'b1;
    rdata = 32'hBAD0_BAD0;
    step();
    chk("drop_valid", 32'(if_id_valid), 0);
    chk("drop_next", 32'(imem_addr), 32'h40);
    rdata = 32'h1234_5678;
    step();
    chk("tgt_valid", 32'(if_id_valid), 1);
    chk("tgt_pc", 32'(if_id_pc), 32'h40);
    chk("tgt_instr", if_id_instr, 32'h1234_5678);

    redirect_valid = 1'b1;
    stall = 1'b1;
    redirect_pc = 9'h100;
    step();
    chk("rs_valid", 32'(if_id_valid), 0);
    chk("rs_instr", if_id_instr, 32'h13);
    chk("rs_addr", 32'(imem_addr), 32'h100);
    stall = 1'b0;

    redirect_pc = 9'h1FC;
    step();
    redirect_valid = 1'b0;
    chk("wr_addr0", 32'(imem_addr), 32'h1FC);
    rdata = 32'hCAFE_F00D;
    step();
    chk("wr_pc", 32'(if_id_pc), 32'h1FC);
    chk("wr_pc4", 32'(if_id_pcplus4), 32'h0);
    chk("wr_instr", if_id_instr, 32'hCAFE_F00D);
    chk("wr_addr", 32'(imem_addr), 32'h0);

    redirect_valid = 1'b1;
    redirect_pc = 9'h042;
    step();
    redirect_valid = 1'b0;
    imem_rdy = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
    chk("mis_addr", 32'(imem_addr), 32'h40);
    chk("mis_flag", 32'(fetch_misalign), 1);
`else
    chk("mis_addr", 32'(imem_addr), 32'h42);
    chk("mis_flag", 32'(fetch_misalign), 0);
`endif
    step();
    chk("mis_clr", 32'(fetch_misalign), 0);

    reset = 1'b1;
    #1;
    chk("mrst_req", 32'(imem_req), 0);
    step();
    chk("mrst_valid", 32'(if_id_valid), 0);
    chk("mrst_pc", 32'(if_id_pc), 0);
    reset = 1'b0;
    #1;
    chk("mrst_addr", 32'(imem_addr), 0);
    chk("mrst_req1", 32'(imem_req), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
